// File: rtl/i2s_dac_serializer.sv
// I2S master serializer: holds one stereo pair and shifts it out MSB first with
// a one-bit delay after each word-select edge. BCLK and LRCK derive from clk.
module i2s_dac_serializer #(
  parameter int SAMPLE_WIDTH = 24,
  parameter int SLOT_BITS    = 32,
  parameter int BCLK_HALF    = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [SAMPLE_WIDTH-1:0] left_in,
  input  logic [SAMPLE_WIDTH-1:0] right_in,
  input  logic                    sample_valid,
  output logic                    sample_ready,
  output logic                    aud_bclk,
  output logic                    aud_daclrck,
  output logic                    aud_dacdat,
  output logic                    underrun
);

  localparam int DIV_W = (BCLK_HALF > 1) ? $clog2(BCLK_HALF) : 1;
  localparam int CNT_W = $clog2(2 * SLOT_BITS);
  localparam int B_W   = $clog2(SLOT_BITS);

  logic [DIV_W-1:0]        r_div;
  logic [CNT_W-1:0]        r_cnt;
  logic [SAMPLE_WIDTH-1:0] r_hold_l;
  logic [SAMPLE_WIDTH-1:0] r_hold_r;
  logic [SAMPLE_WIDTH-1:0] r_frame_l;
  logic [SAMPLE_WIDTH-1:0] r_frame_r;

  logic                    w_div_wrap;
  logic                    w_fall;
  logic                    w_frame_start;
  logic                    w_accept;
  logic [CNT_W-1:0]        w_cnt_next;
  logic [B_W-1:0]          w_bit_idx;
  logic [B_W-1:0]          w_sample_idx;
  logic                    w_right;
  logic [SAMPLE_WIDTH-1:0] w_sel;
  logic                    w_data_bit;

  assign w_div_wrap    = (r_div == DIV_W'(BCLK_HALF - 1));
  assign w_fall        = w_div_wrap && aud_bclk;
  assign w_cnt_next    = (r_cnt == CNT_W'(2 * SLOT_BITS - 1)) ? '0 : r_cnt + 1'b1;
  assign w_frame_start = w_fall && (r_cnt == CNT_W'(2 * SLOT_BITS - 1));
  // The holding register is empty exactly when ready is high.
  assign w_accept      = sample_valid && sample_ready;

  // Slot position is taken from the counter value that becomes current this edge.
  assign w_bit_idx     = w_cnt_next[B_W-1:0];
  assign w_right       = w_cnt_next[CNT_W-1];
  assign w_sel         = w_right ? r_frame_r : r_frame_l;
  assign w_sample_idx  = B_W'(SAMPLE_WIDTH) - w_bit_idx;

  always_comb begin
    w_data_bit = 1'b0;
    if ((w_bit_idx >= B_W'(1)) && (w_bit_idx <= B_W'(SAMPLE_WIDTH))) begin
      w_data_bit = w_sel[w_sample_idx];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_div        <= '0;
      r_cnt        <= CNT_W'(2 * SLOT_BITS - 1);
      r_hold_l     <= '0;
      r_hold_r     <= '0;
      r_frame_l    <= '0;
      r_frame_r    <= '0;
      sample_ready <= 1'b1;
      aud_bclk     <= 1'b0;
      aud_daclrck  <= 1'b0;
      aud_dacdat   <= 1'b0;
      underrun     <= 1'b0;
    end else begin
      underrun <= 1'b0;

      if (w_div_wrap) begin
        r_div    <= '0;
        aud_bclk <= ~aud_bclk;
      end else begin
        r_div <= r_div + 1'b1;
      end

      if (w_fall) begin
        r_cnt       <= w_cnt_next;
        aud_daclrck <= w_right;
        aud_dacdat  <= w_data_bit;
      end

      // Frame start looks at the pre-edge holding state; an empty holding
      // register repeats the previous pair instead of dropping to silence.
      if (w_frame_start) begin
        if (!sample_ready) begin
          r_frame_l <= r_hold_l;
          r_frame_r <= r_hold_r;
        end else begin
          underrun <= 1'b1;
        end
      end

      if (w_frame_start && !sample_ready) begin
        sample_ready <= 1'b1;
      end else if (w_accept) begin
        r_hold_l     <= left_in;
        r_hold_r     <= right_in;
        sample_ready <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_i2s_dac_serializer.sv
// Bench for i2s_dac_serializer: time-based output model, I2S deserializing
// monitor, and directed/random scenarios with literal spot checks.
module tb_i2s_dac_serializer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [23:0] left_in = '0;
  logic [23:0] right_in = '0;
  logic        sample_valid = 1'b0;
  logic        sample_ready;
  logic        aud_bclk;
  logic        aud_daclrck;
  logic        aud_dacdat;
  logic        underrun;

  i2s_dac_serializer dut (
    .clk          (clk),
    .reset        (rst_n),
    .left_in      (left_in),
    .right_in     (right_in),
    .sample_valid (sample_valid),
    .sample_ready (sample_ready),
    .aud_bclk     (aud_bclk),
    .aud_daclrck  (aud_daclrck),
    .aud_dacdat   (aud_dacdat),
    .underrun     (underrun)
  );

  initial forever #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int fail_prints = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      if (fail_prints < 40) begin
        fail_prints++;
        $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
    end
  endtask

  // ---------------- behavioural model ----------------
  // t = number of clk edges since reset release; BCLK phase and the frame
  // bit position follow directly from t.
  int          t = 0;
  bit          m_full = 0;
  logic [23:0] m_hl = '0, m_hr = '0, m_pl = '0, m_pr = '0;
  bit          e_bclk = 0, e_lr = 0, e_dat = 0, e_under = 0, e_ready = 1;
  bit          m_acc;
  int          m_cnt, m_b;
  logic [23:0] m_word;
  logic [47:0] exp_q[$];
  logic [47:0] rx_q[$];

  initial forever begin
    @(posedge clk);
    if (!rst_n) begin
      t = 0; m_full = 0; m_pl = '0; m_pr = '0;
      e_bclk = 0; e_lr = 0; e_dat = 0; e_under = 0; e_ready = 1;
      exp_q.delete();
    end else begin
      m_acc = sample_valid && !m_full;
      t++;
      e_bclk  = ((t / 8) % 2) == 1;
      e_under = 0;
      if (t % 16 == 0) begin
        m_cnt = (t / 16 + 63) % 64;
        if (m_cnt == 0) begin
          if (m_full) begin
            m_pl = m_hl; m_pr = m_hr; m_full = 0;
          end else begin
            e_under = 1;
          end
          exp_q.push_back({m_pl, m_pr});
        end
        m_b    = m_cnt % 32;
        e_lr   = (m_cnt >= 32);
        m_word = e_lr ? m_pr : m_pl;
        e_dat  = (m_b >= 1 && m_b <= 24) ? m_word[24 - m_b] : 1'b0;
      end
      if (m_acc) begin
        m_full = 1; m_hl = left_in; m_hr = right_in;
      end
      e_ready = !m_full;
    end
  end

  // ---------------- per-cycle compare ----------------
  int first_rise = -1, first_under = -1, under_cnt = 0;
  bit prev_bclk = 0;

  initial forever begin
    @(negedge clk);
    if (!rst_n) begin
      check("rst_bclk", aud_bclk, 0);
      check("rst_lrck", aud_daclrck, 0);
      check("rst_dat", aud_dacdat, 0);
      check("rst_underrun", underrun, 0);
      check("rst_ready", sample_ready, 1);
      prev_bclk = 0;
    end else begin
      check($sformatf("bclk@%0d", t), aud_bclk, e_bclk);
      check($sformatf("lrck@%0d", t), aud_daclrck, e_lr);
      check($sformatf("dat@%0d", t), aud_dacdat, e_dat);
      check($sformatf("underrun@%0d", t), underrun, e_under);
      check($sformatf("ready@%0d", t), sample_ready, e_ready);
      if (aud_bclk && !prev_bclk && first_rise < 0) first_rise = t;
      if (underrun) begin
        under_cnt++;
        if (first_under < 0) first_under = t;
      end
      prev_bclk = aud_bclk;
    end
  end

  // ---------------- I2S monitor ----------------
  bit          mon_skip = 1, mon_prev = 1;
  int          mon_pos = 99;
  logic [23:0] mon_l = '0, mon_r = '0;
  logic [47:0] mon_exp;

  initial forever begin
    @(posedge aud_bclk or negedge rst_n);
    if (!rst_n) begin
      mon_skip = 1; mon_prev = 1; mon_pos = 99;
    end else if (mon_skip) begin
      mon_skip = 0;
    end else begin
      if (mon_prev && !aud_daclrck) mon_pos = 0;
      else mon_pos++;
      mon_prev = aud_daclrck;
      if (mon_pos < 64) begin
        check($sformatf("mon_lrck_pos%0d", mon_pos), aud_daclrck, (mon_pos >= 32));
        if (mon_pos >= 1 && mon_pos <= 24) mon_l = {mon_l[22:0], aud_dacdat};
        else if (mon_pos >= 33 && mon_pos <= 56) mon_r = {mon_r[22:0], aud_dacdat};
        else check($sformatf("mon_pad_pos%0d", mon_pos), aud_dacdat, 0);
        if (mon_pos == 56) begin
          rx_q.push_back({mon_l, mon_r});
          if (exp_q.size() == 0) begin
            check("mon_unexpected_frame", 1, 0);
          end else begin
            mon_exp = exp_q.pop_front();
            check("mon_pair", {mon_l, mon_r}, mon_exp);
          end
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic do_reset();
    @(negedge clk);
    rst_n = 0;
    sample_valid = 0;
    repeat (5) @(negedge clk);
    rx_q.delete();
    first_rise = -1; first_under = -1; under_cnt = 0;
    rst_n = 1;
  endtask

  task automatic push(input logic [23:0] l, input logic [23:0] r);
    bit rdy;
    left_in = l; right_in = r; sample_valid = 1;
    for (int i = 0; i < 3000; i++) begin
      rdy = sample_ready;
      @(negedge clk);
      if (rdy) begin
        sample_valid = 0;
        return;
      end
    end
    sample_valid = 0;
    check("push_timeout", 1, 0);
  endtask

  task automatic wait_t(input int target);
    for (int i = 0; i < 5000; i++) begin
      if (t == target) return;
      @(negedge clk);
    end
    check("wait_t_timeout", t, target);
  endtask

  logic [23:0] base_l, base_r;
  bit          rdy_s;

  initial begin
    // Idle after reset: BCLK timing, underruns, silent data.
    do_reset();
    repeat (2100) @(negedge clk);
    check("idle_first_rise", first_rise, 8);
    check("idle_first_underrun", first_under, 16);
    check("idle_underrun_count", under_cnt, 3);
    check("idle_rx_frames", rx_q.size(), 2);
    check("idle_rx_pair0", rx_q[0], 48'h0);

    // Pattern pair pushed before the first frame start, then starved.
    do_reset();
    push(24'h800001, 24'h7FFFFE);
    repeat (2100) @(negedge clk);
    check("pat_rx_frames", rx_q.size(), 2);
    check("pat_rx_pair0", rx_q[0], {24'h800001, 24'h7FFFFE});
    check("pat_rx_pair1_repeat", rx_q[1], {24'h800001, 24'h7FFFFE});
    check("pat_underrun_count", under_cnt, 2);

    // Continuous valid with an incrementing pair.
    do_reset();
    base_l = 24'($urandom); base_r = 24'($urandom);
    left_in = base_l; right_in = base_r; sample_valid = 1;
    for (int i = 0; i < 6200; i++) begin
      rdy_s = sample_ready;
      @(negedge clk);
      if (rdy_s) begin
        left_in = left_in + 1'b1;
        right_in = right_in + 1'b1;
      end
    end
    sample_valid = 0;
    check("cont_rx_pair0", rx_q[0], {base_l, base_r});
    check("cont_rx_pair4", rx_q[4], {base_l + 24'd4, base_r + 24'd4});
    check("cont_underrun_count", under_cnt, 0);

    // Sparse random traffic, mixing repeats and fresh pairs.
    do_reset();
    for (int i = 0; i < 8200; i++) begin
      left_in = 24'($urandom);
      right_in = 24'($urandom);
      sample_valid = ($urandom_range(0, 1499) == 0);
      @(negedge clk);
    end
    sample_valid = 0;

    // Valid raised exactly in the frame-start cycle with holding empty.
    do_reset();
    push(24'h13579B, 24'h2468AC);
    wait_t(1039);
    left_in = 24'hC0FFEE; right_in = 24'h0BADF0; sample_valid = 1;
    @(negedge clk);
    sample_valid = 0;
    check("fs_underrun_at_1040", first_under, 1040);
    repeat (2010) @(negedge clk);
    check("fs_rx_frames", rx_q.size(), 3);
    check("fs_rx_pair1_old", rx_q[1], {24'h13579B, 24'h2468AC});
    check("fs_rx_pair2_new", rx_q[2], {24'hC0FFEE, 24'h0BADF0});
    check("fs_underrun_count", under_cnt, 1);

    // Asynchronous reset in the middle of the right slot.
    do_reset();
    push(24'hABCDEF, 24'h123456);
    wait_t(700);
    check("mid_pre_lrck", aud_daclrck, 1);
    #2 rst_n = 0;
    #1;
    check("async_bclk", aud_bclk, 0);
    check("async_lrck", aud_daclrck, 0);
    check("async_dat", aud_dacdat, 0);
    check("async_underrun", underrun, 0);
    check("async_ready", sample_ready, 1);
    repeat (3) @(negedge clk);
    rx_q.delete();
    first_rise = -1; first_under = -1; under_cnt = 0;
    rst_n = 1;
    repeat (1100) @(negedge clk);
    check("post_rst_first_underrun", first_under, 16);
    check("post_rst_rx_frames", rx_q.size(), 1);
    check("post_rst_rx_zero", rx_q[0], 48'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/i2s_dac_serializer.md
Name: i2s_dac_serializer

Overview:
- Sink for 24-bit synthesizer samples, such as square or mixed voice outputs.
- Buffers one stereo sample pair and serializes it in I2S format to the board audio codec DAC.
- Runs as I2S master: generates bit clock (aud_bclk) and word-select (aud_daclrck) from the 50 MHz system clock.
- Sits between the voice mixer and the codec pins. Upstream uses a valid/ready handshake.

Parameters:
- SAMPLE_WIDTH, 24: bits per channel sample; must be ≤ SLOT_BITS-1.
- SLOT_BITS, 32: BCLK periods per channel slot; 64 per frame.
- BCLK_HALF, 8: clk cycles per BCLK half-period. BCLK = 50 MHz/16 = 3.125 MHz; frame rate is about 48.83 kHz.

Ports:
- clk  input  1  system clock, 50 MHz
- reset  input  1  asynchronous, active-low reset
- left_in  input  SAMPLE_WIDTH  left sample, two's complement
- right_in  input  SAMPLE_WIDTH  right sample, two's complement
- sample_valid  input  1  upstream has a sample pair
- sample_ready  output  1  holding register empty; pair accepted when valid && ready
- aud_bclk  output  1  I2S bit clock
- aud_daclrck  output  1  word select: 0 = left slot, 1 = right slot
- aud_dacdat  output  1  serial data, MSB first
- underrun  output  1  one-clk pulse when a frame starts with no new pair

Behaviour:
- Reset (reset low, async):
  - aud_bclk=0, aud_daclrck=0, aud_dacdat=0, underrun=0, sample_ready=1.
  - Clock divider = 0; bit counter = 2*SLOT_BITS-1.
  - Holding register empty. Frame registers (active L/R) = 0.
- Release is synchronous to the next clk edge. A reset mid-frame aborts the frame immediately, with no partial completion.
- Divider counts 0..BCLK_HALF-1. On reaching BCLK_HALF-1 it wraps to 0 and aud_bclk toggles.
- On each BCLK falling-edge cycle (toggle 1→0), the bit counter increments mod 2*SLOT_BITS.
  - aud_daclrck and aud_dacdat update in that same cycle; all outputs are registered.
  - Codec samples aud_dacdat on BCLK rising edges.
- aud_daclrck = bit counter MSB (bit counter ≥ SLOT_BITS means right slot).
- Slot bit index b = bit counter mod SLOT_BITS:
  - b=0: aud_dacdat=0 (I2S one-bit delay).
  - b=1..SAMPLE_WIDTH: aud_dacdat = active sample bit [SAMPLE_WIDTH-b], so MSB comes first.
  - b>SAMPLE_WIDTH: aud_dacdat=0.
- Frame start is the falling-edge cycle where the bit counter wraps 2*SLOT_BITS-1 → 0. First frame start comes at clk 2*BCLK_HALF after reset release.
  - Holding full: frame registers load from holding; holding becomes empty.
  - Holding empty: frame registers keep the previous pair (last sample repeats, no click to 0); underrun pulses high for exactly that cycle.
- Handshake:
  - sample_ready = holding empty, registered.
  - On valid && ready, left_in/right_in are captured; sample_ready drops next cycle.
  - Inputs are ignored when ready=0. Valid may stay high without duplicate capture.
- Simultaneous accept and frame start (holding empty): frame start sees the pre-edge empty holding, so that frame underruns and repeats. The accepted pair lands in holding and plays next frame.
- Throughput: at most one pair per 2*SLOT_BITS*2*BCLK_HALF = 1024 clk. Upstream is backpressured otherwise.
- No arithmetic on data; bits pass unchanged.

Test Plan:
- Reset held 5 cycles, then released with no input → aud_bclk first rises at clk 8 and first falls at clk 16. Underrun pulses at clk 16, and at every 1024-clk frame start after that. aud_dacdat stays 0. sample_ready=1.
- Push L=0x800001, R=0x7FFFFE before the first frame start → left slot b=1..24 on aud_dacdat reads 1,0×22,1. Right slot reads 0,1×22,0. Pad bits are 0. aud_daclrck is low for 32 BCLKs, then high for 32.
- Hold sample_valid high continuously with an incrementing pair → exactly one pair accepted per 1024 clk. sample_ready low between frame starts. No pair lost or duplicated, checked by deserializing with a reference I2S monitor.
- Push one pair, then starve → that pair repeats in every later frame, with an underrun pulse at each frame start.
- Raise sample_valid in exactly the frame-start cycle with holding empty → underrun pulses. The old pair repeats this frame and the new pair plays in the next frame.
- Assert reset mid-right-slot → all outputs reach reset values without waiting for a clk edge. After release, the frame restarts from the left slot with zeros.
